piso_serializer: RTL

Parallel-in/serial-out serializer that sits directly upstream of the 4-bit SIPO deserializer and drives its serial_in.
It accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock, with frame markers.
An optional inter-frame gap is supported, and back-to-back frames stream with no bubble when the gap is 0.

---
 rtl/serial_link_pkg.sv | 18 +
 rtl/piso_serializer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/serial_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_link_pkg
// Brief    : Shared state encodings and widths for the serial link framers.
// Revision : 1.0 - initial release
// ============================================================================
package serial_link_pkg;

    localparam int GAP_CNT_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Brief    : Valid/ready word in, framed serial bit stream out, optional gap.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer
    import serial_link_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int                   CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     c_last_idx = CNT_W'(WIDTH - 1);
    localparam bit                   c_no_gap   = (GAP_CYCLES == 0);
    localparam logic [GAP_CNT_W-1:0] c_gap_last =
        c_no_gap ? '0 : GAP_CNT_W'(GAP_CYCLES - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [GAP_CNT_W-1:0] r_gap_cnt;

    logic w_last_bit;
    logic w_accept;
    logic w_first_bit;
    logic w_next_bit;

    assign w_last_bit  = (r_state == ST_SHIFT) && (r_bit_cnt == c_last_idx);
    // A new word may be taken on the last bit so gapless frames stream back to back.
    assign in_ready    = (r_state == ST_IDLE) || (w_last_bit && c_no_gap && !flush);
    assign w_accept    = in_valid && in_ready;
    assign w_first_bit = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    assign w_next_bit  = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_last   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_last   <= 1'b0;
            busy         <= 1'b0;

            if (w_accept) begin
                r_state      <= ST_SHIFT;
                r_shift      <= in_data;
                r_bit_cnt    <= '0;
                serial_out   <= w_first_bit;
                serial_valid <= 1'b1;
                frame_start  <= 1'b1;
                busy         <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_SHIFT: begin
                        if (flush || (w_last_bit && c_no_gap)) begin
                            r_state   <= ST_IDLE;
                            r_bit_cnt <= '0;
                        end else if (w_last_bit) begin
                            r_state   <= ST_GAP;
                            r_bit_cnt <= '0;
                            r_gap_cnt <= '0;
                            busy      <= 1'b1;
                        end else begin
                            r_shift      <= MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                                      : {1'b0, r_shift[WIDTH-1:1]};
                            r_bit_cnt    <= r_bit_cnt + 1'b1;
                            serial_out   <= w_next_bit;
                            serial_valid <= 1'b1;
                            frame_last   <= ((r_bit_cnt + 1'b1) == c_last_idx);
                            busy         <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (flush || (r_gap_cnt == c_gap_last)) begin
                            r_state   <= ST_IDLE;
                            r_gap_cnt <= '0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                        r_gap_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
